// File: rtl/logic_shift_unit.sv
// Clocked logic/shift unit: one-cycle bitwise logic ops plus iterative
// shift/rotate ops executed one bit per cycle, with start/busy/finish handshake.
module logic_shift_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               finish,
   output logic [WIDTH-1:0]   C,
   output logic               zero,
   output logic               err
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

   state_t             state_q, state_d;
   logic [3:0]         op_q;
   logic               sign_q;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   logic_res;
   logic [WIDTH-1:0]   shift_res;
   logic               is_logic;
   logic               is_undef;
   logic               is_shift;
   logic               enter_done;

   // Decode the incoming op code class.
   always_comb begin
      is_logic = ~op[3];
      is_undef = op[3] & (op[2:0] > 3'd4);
      is_shift = op[3] & ~is_undef;
   end

   // Bitwise logic result from the live operands (only used on the accepting edge).
   always_comb begin
      logic_res = '0;
      case (op[2:0])
         3'b000:  logic_res = ~A;
         3'b001:  logic_res = ~B;
         3'b010:  logic_res = A & B;
         3'b011:  logic_res = A | B;
         3'b100:  logic_res = A ^ B;
         3'b101:  logic_res = ~(A & B);
         3'b110:  logic_res = ~(A | B);
         default: logic_res = ~(A ^ B);
      endcase
   end

   // One-bit step of the captured shift/rotate op on the working register.
   always_comb begin
      shift_res = work_q;
      case (op_q)
         4'b1000: shift_res = {work_q[WIDTH-2:0], 1'b0};
         4'b1001: shift_res = {1'b0, work_q[WIDTH-1:1]};
         4'b1010: shift_res = {sign_q, work_q[WIDTH-1:1]};
         4'b1011: shift_res = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
         4'b1100: shift_res = {work_q[0], work_q[WIDTH-1:1]};
         default: shift_res = work_q;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is only looked at in idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (is_shift && (shamt != '0)) ? StShift : StDone;
            end
         end
         StShift: begin
            if (cnt_q == SHAMT_W'(1)) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Status outputs decoded from state.
   always_comb begin
      busy   = (state_q != StIdle);
      finish = (state_q == StDone);
   end

   // Next values of the working register and down-counter.
   always_comb begin
      work_d = work_q;
      cnt_d  = cnt_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (is_logic) begin
                  work_d = logic_res;
               end else if (is_undef) begin
                  work_d = '0;
               end else begin
                  work_d = A;
               end
               if (is_shift && (shamt != '0)) begin
                  cnt_d = shamt;
               end
            end
         end
         StShift: begin
            work_d = shift_res;
            cnt_d  = cnt_q - SHAMT_W'(1);
         end
         default: ;
      endcase
   end

   assign enter_done = (state_d == StDone) && (state_q != StDone);

   // Working datapath and operand capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work_q <= '0;
         cnt_q  <= '0;
         op_q   <= '0;
         sign_q <= 1'b0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
         if (state_q == StIdle && start) begin
            op_q   <= op;
            sign_q <= A[WIDTH-1];
         end
      end
   end

   // Result registers: updated only on the edge entering DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         C    <= '0;
         zero <= 1'b1;
         err  <= 1'b0;
      end else if (enter_done) begin
         C    <= work_d;
         zero <= (work_d == '0);
         // Shifts reaching DONE from SHIFT are always defined ops.
         err  <= (state_q == StIdle) && is_undef;
      end
   end

endmodule

// File: tb/tb_logic_shift_unit.sv
// Self-checking bench for logic_shift_unit: cycle model for a 32-bit instance,
// directed literal cases, randomized traffic, and an 8-bit instance.
module tb_logic_shift_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic [4:0]  shamt = '0;
   logic        busy, finish, zero, err;
   logic [31:0] c;

   logic        start8 = 1'b0;
   logic [3:0]  op8 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [2:0]  sh8 = '0;
   logic        busy8, fin8, zero8, err8;
   logic [7:0]  c8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b), .shamt(shamt),
      .busy(busy), .finish(finish), .C(c), .zero(zero), .err(err)
   );

   logic_shift_unit #(.WIDTH(8), .SHAMT_W(3)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8), .shamt(sh8),
      .busy(busy8), .finish(fin8), .C(c8), .zero(zero8), .err(err8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Result of an op from the operation rules, for a w-bit unit.
   function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                              input logic [31:0] y, input int k, input int w);
      logic [31:0] mask;
      logic [31:0] r;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      x = x & mask;
      y = y & mask;
      case (o)
         4'd0:  r = ~x;
         4'd1:  r = ~y;
         4'd2:  r = x & y;
         4'd3:  r = x | y;
         4'd4:  r = x ^ y;
         4'd5:  r = ~(x & y);
         4'd6:  r = ~(x | y);
         4'd7:  r = ~(x ^ y);
         4'd8:  r = x << k;
         4'd9:  r = x >> k;
         4'd10: r = (x >> k) | (x[w-1] ? ~(mask >> k) : 32'd0);
         4'd11: r = (k == 0) ? x : ((x << k) | (x >> (w - k)));
         4'd12: r = (k == 0) ? x : ((x >> k) | (x << (w - k)));
         default: r = 32'd0;
      endcase
      return r & mask;
   endfunction

   function automatic int ref_latency(input logic [3:0] o, input int k);
      return (o < 4'd8 || o > 4'd12 || k == 0) ? 1 : k + 1;
   endfunction

   // Cycle model of the 32-bit instance: m_rem = cycles left until idle.
   int          m_rem = 0;
   logic [31:0] m_c = '0, m_res = '0;
   logic        m_zero = 1'b1, m_err = 1'b0, m_res_err = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rem  <= 0;
         m_c    <= '0;
         m_zero <= 1'b1;
         m_err  <= 1'b0;
      end else if (m_rem == 0) begin
         if (start === 1'b1) begin
            m_rem     <= ref_latency(op, int'(shamt));
            m_res     <= ref_result(op, a, b, int'(shamt), 32);
            m_res_err <= (op > 4'd12);
            if (ref_latency(op, int'(shamt)) == 1) begin
               m_c    <= ref_result(op, a, b, int'(shamt), 32);
               m_zero <= (ref_result(op, a, b, int'(shamt), 32) == 32'd0);
               m_err  <= (op > 4'd12);
            end
         end
      end else begin
         m_rem <= m_rem - 1;
         if (m_rem == 2) begin
            m_c    <= m_res;
            m_zero <= (m_res == 32'd0);
            m_err  <= m_res_err;
         end
      end
   end

   // Compare the 32-bit instance against the model every cycle out of reset.
   always @(negedge clk) begin
      if (!rst) begin
         check("busy", busy, m_rem != 0);
         check("finish", finish, m_rem == 1);
         check("C", c, m_c);
         check("zero", zero, m_zero);
         check("err", err, m_err);
      end
   end

   task automatic run32(input string name, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] k,
                        input logic [31:0] exp_c, input int exp_lat);
      int n = 0;
      int nbusy = 0;
      bit done = 0;
      @(negedge clk);
      op = o; a = x; b = y; shamt = k; start = 1'b1;
      while (!done && n < 64) begin
         @(negedge clk);
         start = 1'b0;
         n++;
         if (busy) nbusy++;
         if (finish) done = 1;
      end
      check({name, " result"}, c, exp_c);
      check({name, " latency"}, n, exp_lat);
      check({name, " busy cycles"}, nbusy, exp_lat);
   endtask

   task automatic run8(input string name, input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [2:0] k,
                       input logic [7:0] exp_c, input int exp_lat);
      int n = 0;
      bit done = 0;
      @(negedge clk);
      op8 = o; a8 = x; b8 = y; sh8 = k; start8 = 1'b1;
      while (!done && n < 32) begin
         @(negedge clk);
         start8 = 1'b0;
         n++;
         if (fin8) done = 1;
      end
      check({name, " result8"}, c8, exp_c);
      check({name, " latency8"}, n, exp_lat);
      check({name, " zero8"}, zero8, exp_c == 8'd0);
   endtask

   initial begin
      int n;
      int nfin;
      bit done;
      logic [3:0] ro;
      logic [7:0] rx, ry;
      logic [2:0] rk;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset C", c, 32'd0);
      check("reset zero", zero, 1'b1);
      check("reset err", err, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset finish", finish, 1'b0);

      // Logic sweep.
      run32("NOTA", 4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd3, 32'h0F0F_EDCB, 1);
      run32("NOTB", 4'd1, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'hF00F_0000, 1);
      run32("AND",  4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00F0_1234, 1);
      run32("OR",   4'd3, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'hFFF0_FFFF, 1);
      run32("XOR",  4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'hFF00_EDCB, 1);
      run32("NAND", 4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'hFF0F_EDCB, 1);
      run32("NOR",  4'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h000F_0000, 1);
      run32("XNOR", 4'd7, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00FF_1234, 1);
      run32("NOTA ones", 4'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 32'h0, 1);
      check("NOTA ones zero", zero, 1'b1);

      // Iterative shifts by 4.
      run32("SLL4", 4'd8,  32'h8000_0001, 32'h0, 5'd4, 32'h0000_0010, 5);
      run32("SRL4", 4'd9,  32'h8000_0001, 32'h0, 5'd4, 32'h0800_0000, 5);
      run32("SRA4", 4'd10, 32'h8000_0001, 32'h0, 5'd4, 32'hF800_0000, 5);
      run32("ROL4", 4'd11, 32'h8000_0001, 32'h0, 5'd4, 32'h0000_0018, 5);
      run32("ROR4", 4'd12, 32'h8000_0001, 32'h0, 5'd4, 32'h1800_0000, 5);

      // Edge amounts.
      run32("SRA0",  4'd10, 32'h8765_4321, 32'h0, 5'd0, 32'h8765_4321, 1);
      run32("SRA31", 4'd10, 32'h8000_0000, 32'h0, 5'd31, 32'hFFFF_FFFF, 32);
      run32("ROR31", 4'd12, 32'h0000_0001, 32'h0, 5'd31, 32'h0000_0002, 32);

      // Undefined op.
      run32("UNDEF", 4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 32'h0, 1);
      check("UNDEF zero", zero, 1'b1);
      check("UNDEF err", err, 1'b1);

      // Handshake: start held high, inputs changed mid-shift.
      @(negedge clk);
      op = 4'd8; a = 32'h1; b = 32'h0; shamt = 5'd8; start = 1'b1;
      n = 0; done = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 3) begin
            op = 4'd2; a = 32'hF0F0_F0F0; b = 32'h0FF0_0FF0;
         end
         if (finish) done = 1;
      end
      check("held first result", c, 32'h0000_0100);
      check("held first latency", n, 9);
      n = 0; done = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (finish) done = 1;
      end
      start = 1'b0;
      check("held second result", c, 32'h00F0_00F0);
      check("held second spacing", n, 2);
      check("held second err", err, 1'b0);

      // Reset in the middle of a long shift.
      @(negedge clk);
      @(negedge clk);
      op = 4'd8; a = 32'h1; shamt = 5'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort C", c, 32'd0);
      check("abort zero", zero, 1'b1);
      check("abort err", err, 1'b0);
      check("abort busy", busy, 1'b0);
      check("abort finish", finish, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      nfin = 0;
      repeat (30) begin
         @(negedge clk);
         if (finish) nfin++;
      end
      check("abort no finish", nfin, 0);

      // Randomized traffic, including starts while busy.
      repeat (1500) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         op = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0:       a = 32'h0;
            1:       a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 5) == 0) ? ~a : $urandom;
         shamt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      end
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);

      // 8-bit instance.
      run8("ROR8", 4'd12, 8'h81, 8'h00, 3'd7, 8'h03, 8);
      repeat (25) begin
         ro = 4'($urandom_range(0, 15));
         rx = 8'($urandom);
         ry = 8'($urandom);
         rk = 3'($urandom_range(0, 7));
         run8("rand8", ro, rx, ry, rk, 8'(ref_result(ro, 32'(rx), 32'(ry), int'(rk), 8)),
              ref_latency(ro, int'(rk)));
         check("rand8 err", err8, ro > 4'd12);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
